// File: rtl/mm_tx_pkg.sv
// Shared definitions for the MAC Merge transmit scheduler.
//   sched_state_e  : scheduler states, encoded as exposed on sched_state
//   MIN_FRAME      : default minimum fragment size in bytes (FCS/mCRC included)
//   MCRC_BYTES     : size of the mCRC that closes a preempted fragment
//   LEN_W          : default width of frame length / fragment byte counts
//   min_frag_bytes : smallest fragment allowed before a preemption point
package mm_tx_pkg;

   localparam int MIN_FRAME  = 64;
   localparam int MCRC_BYTES = 4;
   localparam int LEN_W      = 11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_EXPRESS   = 3'd1,
      ST_PTX       = 3'd2,
      ST_PRE_REQ   = 3'd3,
      ST_PREEMPTED = 3'd4,
      ST_RESUME    = 3'd5
   } sched_state_e;

   // Fragment payload threshold: 60/124/188/252 for addFragSize 0..3 at 64-byte frames.
   function automatic int min_frag_bytes(input int min_frame, input logic [1:0] add_frag);
      return min_frame * (int'(add_frag) + 1) - MCRC_BYTES;
   endfunction

endpackage

// File: rtl/mm_tx_rem_cnt.sv
// Remaining-bytes counter for the preemptable frame in flight.
//   clk, reset_n   : byte clock, asynchronous active-low reset
//   load_i         : load load_val_i (frame accepted for transmission)
//   load_val_i     : frame length in bytes, FCS included
//   dec_i          : one preemptable byte sent
//   rem_ge_min_o   : remaining bytes still form a legal final fragment
module mm_tx_rem_cnt #(
   parameter int LEN_W     = 11,
   parameter int MIN_FRAME = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [LEN_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             rem_ge_min_o
);

   logic [LEN_W-1:0] rem_q, rem_d;

   always_comb begin
      rem_d = rem_q;
      if (load_i) begin
         rem_d = load_val_i;
      end else if (dec_i && (rem_q != '0)) begin
         // Saturate at zero: stray byte strobes must not wrap the count.
         rem_d = rem_q - LEN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign rem_ge_min_o = (rem_q >= LEN_W'(MIN_FRAME));

endmodule

// File: rtl/mm_tx_preempt_sched.sv
// MAC Merge transmit scheduler: arbitrates express vs preemptable frames and
// decides when a preemptable frame may be cut (minimum fragment and minimum
// tail both respected), then sequences its resumption.
//   clk, reset_n          : byte clock, asynchronous active-low reset
//   e_req, e_done         : express frame queued (level) / complete (pulse)
//   p_req, p_len, p_done  : preemptable frame queued, its length, complete
//   frag_end              : preempted fragment closed with mCRC
//   byte_sent, frag_size  : preemptable byte strobe, current fragment size
//   p_allow, verify_ok    : preemption point allowed / preemption verified
//   add_frag_size         : fragment size multiplier minus one
//   hold_req              : scheduled-traffic hold request
//   e_tx, p_tx, hold, preempt : registered controls to the transmit process
//   sched_state           : current state (debug)
//   preempt_cnt           : saturating preemption count
module mm_tx_preempt_sched #(
   parameter int MIN_FRAME = mm_tx_pkg::MIN_FRAME,
   parameter int LEN_W     = mm_tx_pkg::LEN_W,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             e_req,
   input  logic             e_done,
   input  logic             p_req,
   input  logic [LEN_W-1:0] p_len,
   input  logic             p_done,
   input  logic             frag_end,
   input  logic             byte_sent,
   input  logic [LEN_W-1:0] frag_size,
   input  logic             p_allow,
   input  logic             verify_ok,
   input  logic [1:0]       add_frag_size,
   input  logic             hold_req,
   output logic             e_tx,
   output logic             p_tx,
   output logic             hold,
   output logic             preempt,
   output logic [2:0]       sched_state,
   output logic [CNT_W-1:0] preempt_cnt
);

   import mm_tx_pkg::*;

   sched_state_e     state_q, state_d;
   logic             e_tx_q, e_tx_d;
   logic             p_tx_q, p_tx_d;
   logic             preempt_q, preempt_d;
   logic             hold_q, hold_d;
   logic             flight_q, flight_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [LEN_W-1:0] min_frag;
   logic             rem_ge_min;
   logic             can_pre;
   logic             load_rem;

   assign min_frag = LEN_W'(min_frag_bytes(MIN_FRAME, add_frag_size));
   assign can_pre  = verify_ok && p_allow && (frag_size >= min_frag) && rem_ge_min;
   assign hold_d   = hold_req && verify_ok;

   mm_tx_rem_cnt #(
      .LEN_W     (LEN_W),
      .MIN_FRAME (MIN_FRAME)
   ) u_rem_cnt (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_i       (load_rem),
      .load_val_i   (p_len),
      .dec_i        (byte_sent),
      .rem_ge_min_o (rem_ge_min)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_rem = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (e_req) begin
               state_d = ST_EXPRESS;
            end else if (p_req && !hold_d) begin
               state_d  = ST_PTX;
               load_rem = 1'b1;
            end
         end
         ST_EXPRESS: begin
            // A new request arriving with the completion keeps the express path busy.
            if (e_done && !e_req) state_d = ST_IDLE;
         end
         ST_PTX: begin
            if (p_done) begin
               state_d = ST_IDLE;
            end else if ((e_req || hold_d) && can_pre) begin
               state_d = ST_PRE_REQ;
            end
         end
         ST_PRE_REQ: begin
            if (frag_end) begin
               state_d = ST_PREEMPTED;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else if (p_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_PREEMPTED: begin
            // Resume only once no express frame is queued or still on the wire.
            if (!e_req && !hold_d && !(flight_q && !e_done)) state_d = ST_RESUME;
         end
         ST_RESUME: begin
            if (e_req) begin
               state_d = ST_PREEMPTED;
            end else if (byte_sent) begin
               state_d = ST_PTX;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they register with it.
      e_tx_d    = (state_d == ST_EXPRESS) || ((state_d == ST_PREEMPTED) && e_req);
      p_tx_d    = (state_d == ST_PTX) || (state_d == ST_PRE_REQ) ||
                  (state_d == ST_PREEMPTED) || (state_d == ST_RESUME);
      preempt_d = (state_d == ST_PRE_REQ);
      flight_d  = (state_d == ST_PREEMPTED) && (e_req || (flight_q && !e_done));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         e_tx_q    <= 1'b0;
         p_tx_q    <= 1'b0;
         preempt_q <= 1'b0;
         hold_q    <= 1'b0;
         flight_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         e_tx_q    <= e_tx_d;
         p_tx_q    <= p_tx_d;
         preempt_q <= preempt_d;
         hold_q    <= hold_d;
         flight_q  <= flight_d;
         cnt_q     <= cnt_d;
      end
   end

   assign e_tx        = e_tx_q;
   assign p_tx        = p_tx_q;
   assign preempt     = preempt_q;
   assign hold        = hold_q;
   assign sched_state = state_q;
   assign preempt_cnt = cnt_q;

endmodule

// File: tb/tb_mm_tx_preempt_sched.sv
// Testbench for mm_tx_preempt_sched: directed scenarios plus a randomized
// soak compared against a behavioural reference model.
module tb_mm_tx_preempt_sched;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          e_req = 0, e_done = 0, p_req = 0, p_done = 0, frag_end = 0;
   logic          byte_sent = 0, p_allow = 0, verify_ok = 0, hold_req = 0;
   logic [10:0]   p_len = '0, frag_size = '0;
   logic [1:0]    add_frag_size = '0;
   logic          e_tx, p_tx, hold, preempt;
   logic [2:0]    sched_state;
   logic [CW-1:0] preempt_cnt;

   int n_chk = 0;
   int n_pass = 0;

   wire [6:0] obs = {sched_state, e_tx, p_tx, preempt, hold};

   always #5 clk = ~clk;

   mm_tx_preempt_sched #(.MIN_FRAME(64), .LEN_W(11), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .e_req(e_req), .e_done(e_done), .p_req(p_req),
      .p_len(p_len), .p_done(p_done), .frag_end(frag_end), .byte_sent(byte_sent),
      .frag_size(frag_size), .p_allow(p_allow), .verify_ok(verify_ok),
      .add_frag_size(add_frag_size), .hold_req(hold_req), .e_tx(e_tx), .p_tx(p_tx),
      .hold(hold), .preempt(preempt), .sched_state(sched_state), .preempt_cnt(preempt_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      {e_req, e_done, p_req, p_done, frag_end, byte_sent, hold_req} = '0;
      p_allow = 1'b1; verify_ok = 1'b1; add_frag_size = 2'd0;
      p_len = '0; frag_size = '0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
   endtask

   // From PRE_REQ with e_req high: close fragment, finish express, resume, finish frame.
   task automatic finish_preempted();
      frag_end = 1; tick(); frag_end = 0;
      e_req = 0; e_done = 1; tick(); e_done = 0;
      byte_sent = 1; tick(); byte_sent = 0;
      p_done = 1; tick(); p_done = 0;
   endtask

   task automatic send_bytes(input int n);
      for (int i = 1; i <= n; i++) begin
         byte_sent = 1; frag_size = 11'(i); tick();
      end
      byte_sent = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (obs !== 7'b0) $display("FAIL reset_outputs obs=%b exp=%b", obs, 7'b0); else n_pass++;
      n_chk++; if (preempt_cnt !== '0) $display("FAIL reset_cnt got=%0d exp=0", preempt_cnt); else n_pass++;
   endtask

   task automatic test_express();
      logic ptx_seen;
      ptx_seen = 0;
      e_req = 1; tick(); ptx_seen |= p_tx;
      n_chk++; if (obs !== {3'd1, 4'b1000}) $display("FAIL express_start obs=%b exp=%b", obs, {3'd1, 4'b1000}); else n_pass++;
      e_req = 0; tick(); tick(); ptx_seen |= p_tx;
      n_chk++; if (obs !== {3'd1, 4'b1000}) $display("FAIL express_hold obs=%b exp=%b", obs, {3'd1, 4'b1000}); else n_pass++;
      e_done = 1; tick(); e_done = 0; ptx_seen |= p_tx;
      n_chk++; if (obs !== 7'b0) $display("FAIL express_done obs=%b exp=%b", obs, 7'b0); else n_pass++;
      n_chk++; if (ptx_seen !== 1'b0) $display("FAIL express_no_ptx got=%b exp=0", ptx_seen); else n_pass++;
   endtask

   task automatic test_preempt();
      p_req = 1; p_len = 200; tick(); p_req = 0;
      n_chk++; if (obs !== {3'd2, 4'b0100}) $display("FAIL ptx_start obs=%b exp=%b", obs, {3'd2, 4'b0100}); else n_pass++;
      send_bytes(60);
      e_req = 1; tick();
      n_chk++; if (obs !== {3'd3, 4'b0110}) $display("FAIL pre_req obs=%b exp=%b", obs, {3'd3, 4'b0110}); else n_pass++;
      frag_end = 1; tick(); frag_end = 0;
      n_chk++; if (obs !== {3'd4, 4'b1100}) $display("FAIL preempted obs=%b exp=%b", obs, {3'd4, 4'b1100}); else n_pass++;
      n_chk++; if (preempt_cnt !== 4'd1) $display("FAIL cnt_first got=%0d exp=1", preempt_cnt); else n_pass++;
      e_req = 0; e_done = 1; tick(); e_done = 0;
      n_chk++; if (obs !== {3'd5, 4'b0100}) $display("FAIL resume obs=%b exp=%b", obs, {3'd5, 4'b0100}); else n_pass++;
      byte_sent = 1; tick(); byte_sent = 0;
      n_chk++; if (obs !== {3'd2, 4'b0100}) $display("FAIL resume_ptx obs=%b exp=%b", obs, {3'd2, 4'b0100}); else n_pass++;
      p_done = 1; tick(); p_done = 0;
      n_chk++; if (obs !== 7'b0) $display("FAIL ptx_done obs=%b exp=%b", obs, 7'b0); else n_pass++;
   endtask

   task automatic test_min_frag();
      p_req = 1; p_len = 200; tick(); p_req = 0;
      send_bytes(59);
      e_req = 1; tick();
      n_chk++; if (obs !== {3'd2, 4'b0100}) $display("FAIL frag59_nopre obs=%b exp=%b", obs, {3'd2, 4'b0100}); else n_pass++;
      byte_sent = 1; frag_size = 60; tick(); byte_sent = 0;
      n_chk++; if (obs !== {3'd3, 4'b0110}) $display("FAIL frag60_pre obs=%b exp=%b", obs, {3'd3, 4'b0110}); else n_pass++;
      finish_preempted();
      add_frag_size = 3; e_req = 0;
      p_req = 1; p_len = 400; tick(); p_req = 0;
      e_req = 1; frag_size = 251; tick();
      n_chk++; if (obs !== {3'd2, 4'b0100}) $display("FAIL frag251_nopre obs=%b exp=%b", obs, {3'd2, 4'b0100}); else n_pass++;
      frag_size = 252; tick();
      n_chk++; if (obs !== {3'd3, 4'b0110}) $display("FAIL frag252_pre obs=%b exp=%b", obs, {3'd3, 4'b0110}); else n_pass++;
      finish_preempted();
      add_frag_size = 0;
      n_chk++; if (preempt_cnt !== 4'd3) $display("FAIL cnt_three got=%0d exp=3", preempt_cnt); else n_pass++;
   endtask

   task automatic test_short_tail();
      p_req = 1; p_len = 100; tick(); p_req = 0;
      send_bytes(60);
      e_req = 1; tick(); tick();
      n_chk++; if (obs !== {3'd2, 4'b0100}) $display("FAIL rem40_nopre obs=%b exp=%b", obs, {3'd2, 4'b0100}); else n_pass++;
      p_done = 1; tick(); p_done = 0;
      n_chk++; if (obs !== 7'b0) $display("FAIL rem40_idle obs=%b exp=%b", obs, 7'b0); else n_pass++;
      tick();
      n_chk++; if (obs !== {3'd1, 4'b1000}) $display("FAIL rem40_express obs=%b exp=%b", obs, {3'd1, 4'b1000}); else n_pass++;
      e_req = 0; e_done = 1; tick(); e_done = 0;
      p_req = 1; p_len = 124; tick(); p_req = 0;
      send_bytes(60);
      e_req = 1; tick();
      n_chk++; if (obs !== {3'd3, 4'b0110}) $display("FAIL rem64_pre obs=%b exp=%b", obs, {3'd3, 4'b0110}); else n_pass++;
      finish_preempted();
   endtask

   task automatic test_tie_hold();
      e_req = 1; p_req = 1; p_len = 200; tick();
      n_chk++; if (obs !== {3'd1, 4'b1000}) $display("FAIL tie_express obs=%b exp=%b", obs, {3'd1, 4'b1000}); else n_pass++;
      e_req = 0; e_done = 1; tick(); e_done = 0;
      n_chk++; if (obs !== 7'b0) $display("FAIL tie_idle obs=%b exp=%b", obs, 7'b0); else n_pass++;
      tick();
      n_chk++; if (obs !== {3'd2, 4'b0100}) $display("FAIL tie_ptx obs=%b exp=%b", obs, {3'd2, 4'b0100}); else n_pass++;
      p_req = 0; p_done = 1; tick(); p_done = 0;
      hold_req = 1; p_req = 1; tick(); tick();
      n_chk++; if (obs !== {3'd0, 4'b0001}) $display("FAIL hold_blocks obs=%b exp=%b", obs, {3'd0, 4'b0001}); else n_pass++;
      verify_ok = 0; tick();
      n_chk++; if (obs !== {3'd2, 4'b0100}) $display("FAIL hold_unverified obs=%b exp=%b", obs, {3'd2, 4'b0100}); else n_pass++;
      p_req = 0; hold_req = 0; verify_ok = 1; p_done = 1; tick(); p_done = 0;
   endtask

   task automatic test_back_to_back();
      p_req = 1; p_len = 300; frag_size = 60; tick(); p_req = 0;
      e_req = 1; tick();
      frag_end = 1; tick(); frag_end = 0;
      e_done = 1; tick(); e_done = 0;
      n_chk++; if (obs !== {3'd4, 4'b1100}) $display("FAIL b2b_etx_high obs=%b exp=%b", obs, {3'd4, 4'b1100}); else n_pass++;
      e_req = 0; tick();
      n_chk++; if (obs !== {3'd4, 4'b0100}) $display("FAIL b2b_inflight obs=%b exp=%b", obs, {3'd4, 4'b0100}); else n_pass++;
      e_done = 1; tick(); e_done = 0;
      n_chk++; if (obs !== {3'd5, 4'b0100}) $display("FAIL b2b_resume obs=%b exp=%b", obs, {3'd5, 4'b0100}); else n_pass++;
      e_req = 1; tick();
      n_chk++; if (obs !== {3'd4, 4'b1100}) $display("FAIL b2b_repreempt obs=%b exp=%b", obs, {3'd4, 4'b1100}); else n_pass++;
      e_req = 0; e_done = 1; tick(); e_done = 0;
      byte_sent = 1; tick(); byte_sent = 0;
      p_done = 1; tick(); p_done = 0;
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 1; i <= 18; i++) begin
         p_req = 1; p_len = 200; frag_size = 60; tick(); p_req = 0;
         e_req = 1; tick();
         finish_preempted();
         n_chk++;
         if (preempt_cnt !== CW'((i > 15) ? 15 : i)) $display("FAIL sat_cnt iter=%0d got=%0d exp=%0d", i, preempt_cnt, (i > 15) ? 15 : i);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      p_req = 1; p_len = 200; frag_size = 60; tick(); p_req = 0;
      e_req = 1; tick();
      n_chk++; if (obs !== {3'd3, 4'b0110}) $display("FAIL arst_prereq obs=%b exp=%b", obs, {3'd3, 4'b0110}); else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_chk++; if (obs !== 7'b0) $display("FAIL arst_outputs obs=%b exp=%b", obs, 7'b0); else n_pass++;
      n_chk++; if (preempt_cnt !== '0) $display("FAIL arst_cnt got=%0d exp=0", preempt_cnt); else n_pass++;
      e_req = 0; tick();
      reset_n = 1'b1; tick();
   endtask

   // Reference model: phases numbered as exposed on sched_state.
   int   m_ph, m_left, m_cnt;
   bit   m_flight, m_etx;

   task automatic test_random();
      int  mf, np;
      bit  hn, cp, ld;
      logic [6:0] exp_obs;
      do_reset();
      m_ph = 0; m_left = 0; m_cnt = 0; m_flight = 0; m_etx = 0;
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 7) == 0) e_req = ~e_req;
         if ($urandom_range(0, 15) == 0) hold_req = ~hold_req;
         if ($urandom_range(0, 31) == 0) add_frag_size = 2'($urandom_range(0, 3));
         p_req     = ($urandom_range(0, 3) != 0);
         p_len     = 11'($urandom_range(40, 400));
         verify_ok = ($urandom_range(0, 15) != 0);
         p_allow   = ($urandom_range(0, 3) != 0);
         frag_size = 11'($urandom_range(0, 300));
         byte_sent = ((m_ph == 2) || (m_ph == 5)) && ($urandom_range(0, 1) == 1);
         p_done    = ((m_ph == 2) || (m_ph == 3)) && ($urandom_range(0, 19) == 0);
         frag_end  = (m_ph == 3) && !p_done && ($urandom_range(0, 2) == 0);
         e_done    = m_etx && ($urandom_range(0, 5) == 0);

         hn = hold_req && verify_ok;
         mf = 64 * (1 + int'(add_frag_size)) - 4;
         cp = verify_ok && p_allow && (int'(frag_size) >= mf) && (m_left >= 64);
         np = m_ph; ld = 0;
         if (m_ph == 0) begin
            if (e_req) np = 1;
            else if (p_req && !hn) begin np = 2; ld = 1; end
         end else if (m_ph == 1) begin
            if (e_done && !e_req) np = 0;
         end else if (m_ph == 2) begin
            if (p_done) np = 0;
            else if ((e_req || hn) && cp) np = 3;
         end else if (m_ph == 3) begin
            if (frag_end) begin np = 4; if (m_cnt < 15) m_cnt++; end
            else if (p_done) np = 0;
         end else if (m_ph == 4) begin
            if (!e_req && !hn && !(m_flight && !e_done)) np = 5;
         end else begin
            if (e_req) np = 4;
            else if (byte_sent) np = 2;
         end
         m_flight = (np == 4) && (e_req || (m_flight && !e_done));
         if (ld) m_left = int'(p_len);
         else if (byte_sent && m_left > 0) m_left--;
         m_ph  = np;
         m_etx = (np == 1) || ((np == 4) && e_req);
         exp_obs = {3'(np), m_etx, (np >= 2), (np == 3), hn};

         tick();
         n_chk++;
         if (obs !== exp_obs) $display("FAIL rand_outputs cycle=%0d obs=%b exp=%b", c, obs, exp_obs);
         else n_pass++;
         n_chk++;
         if (preempt_cnt !== CW'(m_cnt)) $display("FAIL rand_cnt cycle=%0d got=%0d exp=%0d", c, preempt_cnt, m_cnt);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_express();
      test_preempt();
      test_min_frag();
      test_short_tail();
      test_tie_hold();
      test_back_to_back();
      test_saturate();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
